// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives the combinational instruction memory and
// registers the returned word into a valid/ready IF/ID output stage.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                   IFU_clk,
    input  logic                   IFU_reset,
    output logic [31:0]            IFU_imem_pc,
    input  logic [31:0]            IFU_imem_instruction,
    input  logic                   IFU_redirect,
    input  logic [31:0]            IFU_redirect_target,
    input  logic                   IFU_dec_ready,
    output logic                   IFU_instr_valid,
    output logic [31:0]            IFU_instruction,
    output logic [31:0]            IFU_instr_pc,
    output logic [31:0]            IFU_pc_plus4,
    output logic                   IFU_fault,
    output logic [COUNT_WIDTH-1:0] IFU_fetch_count
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        FAULT
    } state_t;

    state_t                 state, state_n;
    logic [31:0]            pc, pc_n;
    logic                   valid_n;
    logic [31:0]            instruction_n, instr_pc_n, pc_plus4_n;
    logic                   fault_n;
    logic [COUNT_WIDTH-1:0] count_n;
    logic                   advance;

    assign IFU_imem_pc = pc;
    assign advance     = !IFU_instr_valid || IFU_dec_ready;

    always_ff @(posedge IFU_clk) begin
        if (IFU_reset) begin
            state           <= BOOT;
            pc              <= RESET_PC;
            IFU_instr_valid <= 1'b0;
            IFU_instruction <= '0;
            IFU_instr_pc    <= '0;
            IFU_pc_plus4    <= '0;
            IFU_fault       <= 1'b0;
            IFU_fetch_count <= '0;
        end else begin
            state           <= state_n;
            pc              <= pc_n;
            IFU_instr_valid <= valid_n;
            IFU_instruction <= instruction_n;
            IFU_instr_pc    <= instr_pc_n;
            IFU_pc_plus4    <= pc_plus4_n;
            IFU_fault       <= fault_n;
            IFU_fetch_count <= count_n;
        end
    end

    always_comb begin
        state_n       = state;
        pc_n          = pc;
        valid_n       = IFU_instr_valid;
        instruction_n = IFU_instruction;
        instr_pc_n    = IFU_instr_pc;
        pc_plus4_n    = IFU_pc_plus4;
        fault_n       = IFU_fault;
        count_n       = IFU_fetch_count;

        unique case (state)
            BOOT: begin
                state_n = RUN;
            end
            RUN: begin
                // Redirect wins over both advance and stall; a misaligned target traps instead.
                if (IFU_redirect && (IFU_redirect_target[1:0] != 2'b00)) begin
                    state_n = FAULT;
                    fault_n = 1'b1;
                    valid_n = 1'b0;
                end else if (IFU_redirect) begin
                    pc_n    = IFU_redirect_target;
                    valid_n = 1'b0;
                end else if (advance) begin
                    instruction_n = IFU_imem_instruction;
                    instr_pc_n    = pc;
                    pc_plus4_n    = pc + 32'd4;
                    valid_n       = 1'b1;
                    pc_n          = pc + 32'd4;
                    count_n       = IFU_fetch_count + COUNT_WIDTH'(1);
                end
            end
            FAULT: begin
                valid_n = 1'b0;
                fault_n = 1'b1;
            end
            default: begin
                state_n = BOOT;
            end
        endcase
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios with literal checks,
// then random redirect/stall/reset traffic checked every cycle against a model.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imem_pc;
    logic [31:0] imem_instruction;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        dec_ready = 1'b1;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus4;
    logic        fault;
    logic [31:0] fetch_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit #(
        .RESET_PC   (RST_PC),
        .COUNT_WIDTH(32)
    ) dut (
        .IFU_clk             (clk),
        .IFU_reset           (reset),
        .IFU_imem_pc         (imem_pc),
        .IFU_imem_instruction(imem_instruction),
        .IFU_redirect        (redirect),
        .IFU_redirect_target (redirect_target),
        .IFU_dec_ready       (dec_ready),
        .IFU_instr_valid     (instr_valid),
        .IFU_instruction     (instruction),
        .IFU_instr_pc        (instr_pc),
        .IFU_pc_plus4        (pc_plus4),
        .IFU_fault           (fault),
        .IFU_fetch_count     (fetch_count)
    );

    // Instruction memory contents: three fixed words at the bottom, a pattern
    // below 4 KiB, and zero (unmapped) everywhere else.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr == 32'h0) return 32'h2210_0015;
        if (addr == 32'h4) return 32'h2231_0016;
        if (addr == 32'h8) return 32'h0211_A820;
        if (addr < 32'h1000) return {addr[15:0], ~addr[15:0]};
        return 32'h0;
    endfunction

    assign imem_instruction = mem_word(imem_pc);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the fetch stage must hold after each edge.
    bit          m_init = 0;
    bit          m_boot, m_fault, m_valid, m_loaded;
    logic [31:0] m_pc, m_instr, m_ipc, m_count;

    always @(posedge clk) begin
        if (reset) begin
            m_init = 1; m_boot = 1; m_fault = 0; m_valid = 0; m_loaded = 0;
            m_pc = RST_PC; m_instr = 0; m_ipc = 0; m_count = 0;
        end else if (m_init) begin
            if (m_boot) begin
                m_boot = 0;
            end else if (!m_fault) begin
                if (redirect && redirect_target % 4 != 0) begin
                    m_fault = 1; m_valid = 0;
                end else if (redirect) begin
                    m_pc = redirect_target; m_valid = 0;
                end else if (!m_valid || dec_ready) begin
                    m_instr = mem_word(m_pc);
                    m_ipc = m_pc;
                    m_pc = m_pc + 4;
                    m_valid = 1; m_loaded = 1;
                    m_count = m_count + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            check("imem_pc", imem_pc, m_pc);
            check("valid", {31'b0, instr_valid}, {31'b0, m_valid});
            check("fault", {31'b0, fault}, {31'b0, m_fault});
            check("fetch_count", fetch_count, m_count);
            if (m_valid || !m_loaded) begin
                check("instruction", instruction, m_instr);
                check("instr_pc", instr_pc, m_ipc);
                check("pc_plus4", pc_plus4, m_loaded ? m_ipc + 4 : 32'h0);
            end
        end
    end

    // Drive inputs for one edge, then return just after the following falling edge.
    task automatic step(input logic r, input logic d, input logic [31:0] t, input logic rdy);
        reset = r; redirect = d; redirect_target = t; dec_ready = rdy;
        @(negedge clk); #1;
    endtask

    initial begin
        @(negedge clk); #1;
        step(1, 0, 0, 1);
        check("rst_valid", {31'b0, instr_valid}, 32'h0);
        check("rst_imem_pc", imem_pc, 32'h0);
        check("rst_count", fetch_count, 32'h0);

        // boot bubble then three back-to-back fetches
        step(0, 0, 0, 1);
        check("boot_valid", {31'b0, instr_valid}, 32'h0);
        step(0, 0, 0, 1);
        check("t1_instr0", instruction, 32'h2210_0015);
        check("t1_pc0", instr_pc, 32'h0);
        check("t1_plus4", pc_plus4, 32'h4);
        step(0, 0, 0, 1);
        check("t1_instr1", instruction, 32'h2231_0016);
        step(0, 0, 0, 1);
        check("t1_instr2", instruction, 32'h0211_A820);
        check("t1_count", fetch_count, 32'd3);

        // stall holding pc 0xC
        step(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0);
            check("t2_hold_ipc", instr_pc, 32'hC);
            check("t2_hold_imem", imem_pc, 32'h10);
        end
        step(0, 0, 0, 1);
        check("t2_next_ipc", instr_pc, 32'h10);
        check("t2_count", fetch_count, 32'd5);

        // redirect during a stall
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
        check("t3_pre_ipc", instr_pc, 32'h24);
        step(0, 1, 32'h2C, 0);
        check("t3_flush", {31'b0, instr_valid}, 32'h0);
        check("t3_imem", imem_pc, 32'h2C);
        step(0, 0, 0, 1);
        check("t3_tgt_ipc", instr_pc, 32'h2C);
        check("t3_count", fetch_count, 32'd11);

        // misaligned redirect traps until reset
        step(0, 1, 32'h31, 1);
        check("t4_fault", {31'b0, fault}, 32'h1);
        for (int i = 0; i < 10; i++) begin
            step(0, 1'($urandom_range(0, 1)), {$urandom_range(0, 255), 2'b00}, 1'($urandom_range(0, 1)));
            check("t4_stuck_fault", {31'b0, fault, instr_valid}, 32'h2);
            check("t4_stuck_pc", imem_pc, 32'h30);
        end
        step(1, 0, 0, 1);
        check("t4_clr", {31'b0, fault}, 32'h0);
        check("t4_pc", imem_pc, RST_PC);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        // wrap at top of address space
        step(0, 1, 32'hFFFF_FFFC, 1);
        step(0, 0, 0, 1);
        check("t5_ipc", instr_pc, 32'hFFFF_FFFC);
        check("t5_plus4", pc_plus4, 32'h0);
        check("t5_nop", instruction, 32'h0);
        step(0, 0, 0, 1);
        check("t5_wrap_instr", instruction, 32'h2210_0015);

        // reset mid-stall, and reset coinciding with a redirect
        step(0, 1, 32'h18, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        check("t6_stall_ipc", instr_pc, 32'h18);
        step(1, 0, 0, 0);
        check("t6a_zero", instr_pc | instruction | pc_plus4 | fetch_count, 32'h0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("t6a_ipc", instr_pc, RST_PC);
        step(1, 1, 32'h40, 1);
        check("t6b_imem", imem_pc, RST_PC);
        step(0, 1, 32'h80, 1);
        check("t6b_boot_ignore", imem_pc, RST_PC);
        step(0, 0, 0, 1);
        check("t6b_ipc", instr_pc, RST_PC);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic        r, d, rdy;
            logic [31:0] t;
            r   = ($urandom_range(0, 99) == 0);
            d   = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 19))
                0:       t = 32'hFFFF_FFF8;
                1:       t = {$urandom_range(0, 1023), 2'b01};
                default: t = {20'b0, 10'($urandom_range(0, 1023)), 2'b00};
            endcase
            step(r, d, t, rdy);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
